// File: rtl/adc_avg_filter_if.sv
// Sample-in / average-out bundle between the SPI ADC stage, the averaging filter and the LED logic.
// The slave modport is the filter side; the master modport is the producer/consumer side.
interface adc_avg_filter_if #(
  parameter int DATA_W = 12
) ();
  logic [DATA_W-1:0] i_DATA;
  logic              i_DATA_VALID;
  logic [DATA_W-1:0] o_AVG;
  logic              o_AVG_VALID;
  logic              o_ABOVE;
  logic [DATA_W-1:0] o_MIN;
  logic [DATA_W-1:0] o_MAX;

  modport master (
    output i_DATA,
    output i_DATA_VALID,
    input  o_AVG,
    input  o_AVG_VALID,
    input  o_ABOVE,
    input  o_MIN,
    input  o_MAX
  );

  modport slave (
    input  i_DATA,
    input  i_DATA_VALID,
    output o_AVG,
    output o_AVG_VALID,
    output o_ABOVE,
    output o_MIN,
    output o_MAX
  );
endinterface

// File: rtl/adc_avg_filter.sv
// Block average of 2**LOG2_N ADC samples with a hysteresis threshold flag.
// Optional per-window min/max tracking is built only when AVG_MINMAX_EN is defined.
module adc_avg_filter #(
  parameter int                DATA_W    = 12,
  parameter int                LOG2_N    = 3,
  parameter logic [DATA_W-1:0] THRESH_HI = 12'd2600,
  parameter logic [DATA_W-1:0] THRESH_LO = 12'd2400
) (
  input logic            clk,
  input logic            reset,
  adc_avg_filter_if.slave bus
);
  localparam int                ACC_W    = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_ZERO = {LOG2_N{1'b0}};
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
  localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic              valid_d_r;
  logic              capture_s;
  logic              last_s;
  logic [ACC_W-1:0]  acc_r, acc_s, sum_s;
  logic [LOG2_N-1:0] count_r, count_s;
  logic [DATA_W-1:0] avg_r, avg_s;
  logic              avg_valid_r, avg_valid_s;
  logic              above_r, above_s;

  function automatic logic hyst_next(input logic [DATA_W-1:0] avg, input logic prev);
    logic res;
    if (avg >= THRESH_HI) begin
      res = 1'b1;
    end else if (avg <= THRESH_LO) begin
      res = 1'b0;
    end else begin
      res = prev;
    end
    return res;
  endfunction

  // The delayed valid resets to 1 so a level held through reset is never seen as an edge.
  assign capture_s = bus.i_DATA_VALID & ~valid_d_r;
  assign sum_s     = acc_r + {{LOG2_N{1'b0}}, bus.i_DATA};
  assign last_s    = capture_s && (state_r == ST_ACC) && (count_r == CNT_LAST);

  // Next-state: accumulate, and on the Nth capture load the result registers so they
  // are already valid during the OUT cycle that carries the strobe.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    count_s     = count_r;
    avg_s       = avg_r;
    avg_valid_s = 1'b0;
    above_s     = above_r;
    case (state_r)
      ST_ACC: begin
        if (last_s) begin
          avg_s       = sum_s[ACC_W-1:LOG2_N];
          avg_valid_s = 1'b1;
          above_s     = hyst_next(sum_s[ACC_W-1:LOG2_N], above_r);
          acc_s       = {ACC_W{1'b0}};
          count_s     = CNT_ZERO;
          state_s     = ST_OUT;
        end else if (capture_s) begin
          acc_s   = sum_s;
          count_s = count_r + CNT_ONE;
        end else begin
          acc_s = acc_r;
        end
      end
      ST_OUT: begin
        state_s = ST_ACC;
        if (capture_s) begin
          acc_s   = {{LOG2_N{1'b0}}, bus.i_DATA};
          count_s = CNT_ONE;
        end else begin
          acc_s = acc_r;
        end
      end
      default: begin
        state_s = ST_ACC;
        acc_s   = {ACC_W{1'b0}};
        count_s = CNT_ZERO;
      end
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_ACC;
      valid_d_r   <= 1'b1;
      acc_r       <= {ACC_W{1'b0}};
      count_r     <= CNT_ZERO;
      avg_r       <= {DATA_W{1'b0}};
      avg_valid_r <= 1'b0;
      above_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      valid_d_r   <= bus.i_DATA_VALID;
      acc_r       <= acc_s;
      count_r     <= count_s;
      avg_r       <= avg_s;
      avg_valid_r <= avg_valid_s;
      above_r     <= above_s;
    end
  end

  assign bus.o_AVG       = avg_r;
  assign bus.o_AVG_VALID = avg_valid_r;
  assign bus.o_ABOVE     = above_r;

`ifdef AVG_MINMAX_EN
  logic              first_s;
  logic [DATA_W-1:0] run_min_r, run_max_r;
  logic [DATA_W-1:0] win_min_s, win_max_s;
  logic [DATA_W-1:0] min_r, max_r, min_s, max_s;

  function automatic logic [DATA_W-1:0] min_of(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max_of(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign first_s = capture_s && ((state_r == ST_OUT) || (count_r == CNT_ZERO));

  // Running extremes including the sample being captured now; published with the average.
  always_comb begin
    min_s = min_r;
    max_s = max_r;
    if (first_s) begin
      win_min_s = bus.i_DATA;
      win_max_s = bus.i_DATA;
    end else begin
      win_min_s = min_of(run_min_r, bus.i_DATA);
      win_max_s = max_of(run_max_r, bus.i_DATA);
    end
    if (last_s) begin
      min_s = win_min_s;
      max_s = win_max_s;
    end else begin
      min_s = min_r;
      max_s = max_r;
    end
  end

  // Min/max tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_min_r <= {DATA_W{1'b0}};
      run_max_r <= {DATA_W{1'b0}};
      min_r     <= {DATA_W{1'b0}};
      max_r     <= {DATA_W{1'b0}};
    end else begin
      if (capture_s) begin
        run_min_r <= win_min_s;
        run_max_r <= win_max_s;
      end
      min_r <= min_s;
      max_r <= max_s;
    end
  end

  assign bus.o_MIN = min_r;
  assign bus.o_MAX = max_r;
`else
  assign bus.o_MIN = {DATA_W{1'b0}};
  assign bus.o_MAX = {DATA_W{1'b0}};
`endif

endmodule
